fp_sqrt_sequencer: RTL and testbench

Issue/completion sequencer placed directly in front of the floating-point square-root unit. Accepts single-precision operands over a valid/ready handshake, launches the iterative square-root core with a one-cycle start pulse, holds operands stable while the core runs, and captures result and flags. Presents the result downstream over a valid/ready handshake and accumulates sticky exception flags. Adds a watchdog so that a core that never returns cannot stall the pipeline.

---
 rtl/fp_sqrt_pkg.sv | 22 ++
 rtl/fp_special_classify.sv | 23 ++
 rtl/fp_sqrt_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fp_sqrt_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg: shared types and constants for the square-root sequencer.
// Contents: FSM state enum, canonical NaN, 1.0, flag bit indices, flag values.
package fp_sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] ONE  = 32'h3F800000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0] FLAGS_NV      = 5'b10000;
    localparam logic [4:0] FLAGS_TIMEOUT = 5'b10000;

endpackage

// File: rtl/fp_special_classify.sv
// fp_special_classify: combinational classifier of special single operands.
// Ports: a (operand) -> is_nan, is_pinf, is_zero, is_one, is_neg.
module fp_special_classify
    import fp_sqrt_pkg::*;
(
    input  logic [31:0] a,
    output logic        is_nan,
    output logic        is_pinf,
    output logic        is_zero,
    output logic        is_one,
    output logic        is_neg
);

    logic w_exp_ones;

    assign w_exp_ones = (a[30:23] == 8'hFF);
    assign is_nan     = w_exp_ones & (a[22:0] != 23'd0);
    assign is_pinf    = (a == 32'h7F800000);
    assign is_zero    = (a[30:0] == 31'd0);
    assign is_one     = (a == ONE);
    assign is_neg     = a[31];

endmodule

// File: rtl/fp_sqrt_sequencer.sv
// fp_sqrt_sequencer: issue/completion sequencer for the iterative sqrt core.
// Ports: in_* request handshake, sq_* core side, out_* result handshake,
// fflags_clr/fflags_acc sticky flags. Option: FP_SQRT_BYPASS_EN.
module fp_sqrt_sequencer
    import fp_sqrt_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             sq_start,
    output logic [31:0]      sq_a,
    output logic [2:0]       sq_rm,
    input  logic [31:0]      sq_y,
    input  logic [4:0]       sq_flags,
    input  logic             sq_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    input  logic             fflags_clr,
    output logic [4:0]       fflags_acc
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_a;
    logic [2:0]         r_rm;
    logic [TAG_W-1:0]   r_tag;
    logic               r_start;
    logic               r_out_valid;
    logic [31:0]        r_out_y;
    logic [4:0]         r_out_flags;
    logic [4:0]         r_fflags;

    logic               w_accept;
    logic               w_hs;
    logic               w_bypass;
    logic [31:0]        w_byp_y;
    logic [4:0]         w_byp_flags;

    // Ready in IDLE, or in HOLD when the held result leaves this cycle.
    assign in_ready = ~rst & ((r_state == ST_IDLE) |
                              ((r_state == ST_HOLD) & out_ready));
    assign w_accept = in_valid & in_ready;
    assign w_hs     = r_out_valid & out_ready;

`ifdef FP_SQRT_BYPASS_EN
    logic w_is_nan;
    logic w_is_pinf;
    logic w_is_zero;
    logic w_is_one;
    logic w_is_neg;
    logic w_neg_nz;

    fp_special_classify u_classify (
        .a       (in_a),
        .is_nan  (w_is_nan),
        .is_pinf (w_is_pinf),
        .is_zero (w_is_zero),
        .is_one  (w_is_one),
        .is_neg  (w_is_neg)
    );

    // NaN takes precedence over its sign bit; -inf counts as negative.
    assign w_neg_nz    = w_is_neg & ~w_is_zero & ~w_is_nan;
    assign w_bypass    = w_neg_nz | w_is_nan | w_is_zero |
                         w_is_pinf | w_is_one;
    assign w_byp_y     = w_neg_nz ? QNAN : in_a;
    assign w_byp_flags = w_neg_nz ? FLAGS_NV : 5'd0;
`else
    assign w_bypass    = 1'b0;
    assign w_byp_y     = 32'd0;
    assign w_byp_flags = 5'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_rm        <= '0;
            r_tag       <= '0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_flags <= '0;
            r_fflags    <= '0;
        end else begin
            r_start <= 1'b0;

            if (w_hs) begin
                r_fflags <= (fflags_clr ? 5'd0 : r_fflags) | r_out_flags;
            end else if (fflags_clr) begin
                r_fflags <= '0;
            end

            if (w_accept) begin
                r_a   <= in_a;
                r_rm  <= in_rm;
                r_tag <= in_tag;
            end

            unique case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if ((r_state == ST_IDLE) || w_hs) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (w_accept) begin
                            if (w_bypass) begin
                                r_out_y     <= w_byp_y;
                                r_out_flags <= w_byp_flags;
                                r_out_valid <= 1'b1;
                                r_state     <= ST_HOLD;
                            end else begin
                                r_start <= 1'b1;
                                r_state <= ST_START;
                            end
                        end
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real result beats the watchdog in the same cycle.
                    if (sq_valid) begin
                        r_out_y     <= sq_y;
                        r_out_flags <= sq_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_out_y     <= QNAN;
                        r_out_flags <= FLAGS_TIMEOUT;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sq_start   = r_start;
    assign sq_a       = r_a;
    assign sq_rm      = r_rm;
    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;
    assign out_flags  = r_out_flags;
    assign out_tag    = r_tag;
    assign fflags_acc = r_fflags;

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// tb_fp_sqrt_sequencer: directed self-checking bench for fp_sqrt_sequencer.
// Stub core driven by hand; TIMEOUT=8 so the watchdog fires at cycle 10.
module tb_fp_sqrt_sequencer;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             sq_start;
    logic [31:0]      sq_a;
    logic [2:0]       sq_rm;
    logic [31:0]      sq_y;
    logic [4:0]       sq_flags;
    logic             sq_valid;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [4:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic             fflags_clr;
    logic [4:0]       fflags_acc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_start = 0;
    logic [31:0] held_y;

    fp_sqrt_sequencer #(
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_rm      (in_rm),
        .in_tag     (in_tag),
        .sq_start   (sq_start),
        .sq_a       (sq_a),
        .sq_rm      (sq_rm),
        .sq_y       (sq_y),
        .sq_flags   (sq_flags),
        .sq_valid   (sq_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .fflags_clr (fflags_clr),
        .fflags_acc (fflags_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sq_start) n_start <= n_start + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_rm      = '0;
        in_tag     = '0;
        sq_y       = '0;
        sq_flags   = '0;
        sq_valid   = 1'b0;
        out_ready  = 1'b0;
        fflags_clr = 1'b0;

        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sq_start", sq_start, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_fflags", fflags_acc, 0);
        chk("rst_sq_a", sq_a, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Basic result: 4.0 -> 2.0, NX flag, core answers in cycle 5.
        in_valid = 1'b1;
        in_a     = 32'h40800000;
        in_rm    = 3'b000;
        in_tag   = 4'd3;
        tick();
        in_valid = 1'b0;
        chk("b_start_c1", sq_start, 1);
        chk("b_sq_a", sq_a, 32'h40800000);
        tick();
        chk("b_start_c2", sq_start, 0);
        tick();
        tick();
        tick();
        sq_valid = 1'b1;
        sq_y     = 32'h40000000;
        sq_flags = 5'b00001;
        chk("b_valid_c5", out_valid, 0);
        tick();
        sq_valid = 1'b0;
        chk("b_valid_c6", out_valid, 1);
        chk("b_out_y", out_y, 32'h40000000);
        chk("b_out_tag", out_tag, 3);
        chk("b_out_flags", out_flags, 5'b00001);
        chk("b_one_start", n_start, 1);

        // Back-to-back: stall 5 cycles with a pending request.
        in_valid = 1'b1;
        in_a     = 32'h41100000;
        in_tag   = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bb_stall_y", out_y, 32'h40000000);
            chk("bb_stall_rdy", in_ready, 0);
            chk("bb_stall_vld", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bb_in_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bb_start", sq_start, 1);
        chk("bb_vld_drop", out_valid, 0);
        chk("bb_sq_a", sq_a, 32'h41100000);
        chk("bb_fflags1", fflags_acc, 5'b00001);
        tick();
        tick();
        sq_valid = 1'b1;
        sq_y     = 32'h40400000;
        sq_flags = 5'b00010;
        tick();
        sq_valid = 1'b0;
        chk("bb_out_vld", out_valid, 1);
        chk("bb_out_y", out_y, 32'h40400000);
        chk("bb_out_tag", out_tag, 5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("st_fflags2", fflags_acc, 5'b00011);
        chk("bb_idle_vld", out_valid, 0);

        // Watchdog: the core stays silent.
        in_valid = 1'b1;
        in_a     = 32'h40000000;
        in_tag   = 4'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("wd_vld_c9", out_valid, 0);
        tick();
        chk("wd_vld_c10", out_valid, 1);
        chk("wd_out_y", out_y, 32'h7FC00000);
        chk("wd_out_flags", out_flags, 5'b10000);
        chk("wd_out_tag", out_tag, 7);
        sq_valid = 1'b1;
        sq_y     = 32'h12345678;
        sq_flags = 5'b00001;
        tick();
        sq_valid = 1'b0;
        chk("wd_late_y", out_y, 32'h7FC00000);
        chk("wd_late_flags", out_flags, 5'b10000);

        // Sticky clear together with a handshake carrying NV.
        out_ready  = 1'b1;
        fflags_clr = 1'b1;
        tick();
        out_ready  = 1'b0;
        fflags_clr = 1'b0;
        chk("st_clr_hs", fflags_acc, 5'b10000);
        chk("wd_idle_vld", out_valid, 0);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("st_clr_only", fflags_acc, 5'b00000);

`ifdef FP_SQRT_BYPASS_EN
        in_valid = 1'b1;
        in_a     = 32'hBF800000;
        in_tag   = 4'd9;
        tick();
        in_valid = 1'b0;
        chk("by_neg_vld", out_valid, 1);
        chk("by_neg_y", out_y, 32'h7FC00000);
        chk("by_neg_flags", out_flags, 5'b10000);
        chk("by_neg_start", sq_start, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h7F800000;
        in_tag    = 4'd10;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("by_inf_vld", out_valid, 1);
        chk("by_inf_y", out_y, 32'h7F800000);
        chk("by_inf_flags", out_flags, 5'b00000);
        chk("by_inf_start", sq_start, 0);
        out_ready = 1'b1;
        tick();
        out_ready  = 1'b0;
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
`endif

        // Reset in WAIT discards the request.
        in_valid = 1'b1;
        in_a     = 32'h40800000;
        in_tag   = 4'd2;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        held_y = out_y;
        rst = 1'b1;
        #1;
        chk("mr_vld", out_valid, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_sq_a", sq_a, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_in_ready_rel", in_ready, 1);
        sq_valid = 1'b1;
        sq_y     = 32'h40000000;
        sq_flags = 5'b00001;
        tick();
        sq_valid = 1'b0;
        tick();
        chk("mr_no_out", out_valid, 0);
        chk("mr_out_y", out_y, 0);
        chk("mr_no_start", sq_start, 0);
        chk("starts_total", n_start, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
